// File: rtl/adda_pkg.sv
// rtl/adda_pkg.sv - shared state encoding and pipeline latency for the FIFO scaler
package adda_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Cycles from an input FIFO read strobe to the matching output FIFO write.
    localparam int PIPE_LATENCY = 2;

endpackage

// File: rtl/amp_scale.sv
// rtl/amp_scale.sv - combinational decimating shift and truncation of one sample word
module amp_scale #(
    parameter int SAMPLE_RATE = 4,
    parameter int DATA_WIDTH  = 14
) (
    input  logic [DATA_WIDTH+SAMPLE_RATE-1:0] din_i,
    input  logic [2:0]                        shift_i,
    output logic [DATA_WIDTH-1:0]             dout_o
);

    logic [DATA_WIDTH+SAMPLE_RATE-1:0] shifted;

    // Remove the accumulation gain plus the requested attenuation, keep the low bits.
    always_comb begin
        shifted = din_i >> (SAMPLE_RATE + int'(shift_i));
        dout_o  = shifted[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/fifo_scale_ctrl.sv
// rtl/fifo_scale_ctrl.sv - frame controller moving scaled words from an input FIFO to an output FIFO
import adda_pkg::*;

module fifo_scale_ctrl #(
    parameter int SAMPLE_RATE = 4,
    parameter int DATA_WIDTH  = 14,
    parameter int LEN_WIDTH   = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             abort,
    input  logic [LEN_WIDTH-1:0]             frame_len,
    input  logic [2:0]                       shift,
    input  logic                             infifo_almst_empty,
    output logic                             infifo_rd_en,
    input  logic [DATA_WIDTH+SAMPLE_RATE-1:0] infifo_dout,
    input  logic                             outfifo_almst_full,
    input  logic                             inbusy,
    output logic                             outfifo_wr_en,
    output logic [DATA_WIDTH-1:0]            outfifo_din,
    output logic                             busy,
    output logic                             done,
    output logic [LEN_WIDTH-1:0]             wr_cnt
);

    state_e                  state_q, state_d;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [2:0]              shift_q;
    logic [LEN_WIDTH-1:0]    rd_cnt_q, rd_cnt_d;
    logic [LEN_WIDTH-1:0]    wr_cnt_q, wr_cnt_d;
    logic [PIPE_LATENCY-1:0] vld_q;
    logic [DATA_WIDTH-1:0]   din_q;
    logic [DATA_WIDTH-1:0]   scaled;
    logic                    rd_en;
    logic                    start_acc;

    assign start_acc     = (state_q == ST_IDLE) && start;
    assign infifo_rd_en  = rd_en;
    assign outfifo_wr_en = vld_q[PIPE_LATENCY-1];
    assign outfifo_din   = din_q;
    assign wr_cnt        = wr_cnt_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);

    amp_scale #(
        .SAMPLE_RATE (SAMPLE_RATE),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_amp_scale (
        .din_i   (infifo_dout),
        .shift_i (shift_q),
        .dout_o  (scaled)
    );

    // Frame sequencing and read gating; abort only matters while reads are being issued.
    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                rd_en = !infifo_almst_empty && !outfifo_almst_full && !inbusy
                        && (rd_cnt_q < len_q);
                if ((rd_cnt_q == len_q) || abort) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (vld_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read/write counters: cleared on an accepted start, never wrap because reads stop at frame_len.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (start_acc) begin
            rd_cnt_d = '0;
            wr_cnt_d = '0;
        end else begin
            if (rd_en) begin
                rd_cnt_d = rd_cnt_q + LEN_WIDTH'(1);
            end
            if (vld_q[PIPE_LATENCY-1]) begin
                wr_cnt_d = wr_cnt_q + LEN_WIDTH'(1);
            end
        end
    end

    // Control registers; frame parameters are frozen at the accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            shift_q  <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            if (start_acc) begin
                len_q   <= frame_len;
                shift_q <= shift;
            end
        end
    end

    // Fixed-latency data pipe: read strobe, then FIFO data scaled straight into the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            din_q <= '0;
        end else begin
            vld_q <= {vld_q[PIPE_LATENCY-2:0], rd_en};
            if (vld_q[0]) begin
                din_q <= scaled;
            end
        end
    end

endmodule

// File: tb/tb_fifo_scale_ctrl.sv
// tb/tb_fifo_scale_ctrl.sv - scoreboard bench for fifo_scale_ctrl
module tb_fifo_scale_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] frame_len;
    logic [2:0]  shift;
    logic        infifo_almst_empty;
    logic        infifo_rd_en;
    logic [17:0] infifo_dout = '0;
    logic        outfifo_almst_full;
    logic        inbusy;
    logic        outfifo_wr_en;
    logic [13:0] outfifo_din;
    logic        busy;
    logic        done;
    logic [15:0] wr_cnt;

    int checks   = 0;
    int failures = 0;

    logic [17:0] mem  [0:255];
    logic [13:0] expv [0:255];
    int          rd_ptr = 0;
    logic [13:0] exp_q [$];

    int          n_rd = 0;
    int          n_wr = 0;
    int          n_done = 0;
    logic [1:0]  rd_hist = '0;

    int base_rd, base_wr, base_done;

    fifo_scale_ctrl #(
        .SAMPLE_RATE (4),
        .DATA_WIDTH  (14),
        .LEN_WIDTH   (16)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .abort              (abort),
        .frame_len          (frame_len),
        .shift              (shift),
        .infifo_almst_empty (infifo_almst_empty),
        .infifo_rd_en       (infifo_rd_en),
        .infifo_dout        (infifo_dout),
        .outfifo_almst_full (outfifo_almst_full),
        .inbusy             (inbusy),
        .outfifo_wr_en      (outfifo_wr_en),
        .outfifo_din        (outfifo_din),
        .busy               (busy),
        .done               (done),
        .wr_cnt             (wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Input FIFO model: data appears one cycle after the read strobe; expected output is queued.
    always @(posedge clk) begin
        if (rst_n && infifo_rd_en) begin
            infifo_dout <= mem[rd_ptr];
            exp_q.push_back(expv[rd_ptr]);
            rd_ptr <= rd_ptr + 1;
        end
    end

    // Monitor: pops the scoreboard on every output write and checks latency and read gating.
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_hist = '0;
            check("rst_wr_en", 32'(outfifo_wr_en), 32'd0);
        end else begin
            if (outfifo_wr_en) begin
                n_wr++;
                check("wr_latency", 32'(rd_hist[1]), 32'd1);
                if (exp_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
                else                   check("wr_data", 32'(outfifo_din), 32'(exp_q.pop_front()));
            end
            if (infifo_rd_en) begin
                n_rd++;
                check("rd_gate", 32'(outfifo_almst_full | infifo_almst_empty | inbusy), 32'd0);
            end
            if (done) n_done++;
            rd_hist = {rd_hist[0], infifo_rd_en};
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int i, input logic [17:0] w, input logic [13:0] e);
        mem[rd_ptr + i]  = w;
        expv[rd_ptr + i] = e;
    endtask

    task automatic start_frame(input logic [15:0] len, input logic [2:0] sh, input logic ab);
        base_rd   = n_rd;
        base_wr   = n_wr;
        base_done = n_done;
        start     = 1'b1;
        abort     = ab;
        frame_len = len;
        shift     = sh;
        tick;
        start     = 1'b0;
        abort     = 1'b0;
        frame_len = 16'hFFFF;
        shift     = 3'd5;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (n_done > base_done) break;
            tick;
        end
        check("done_seen", 32'(n_done > base_done), 32'd1);
        tick;
        tick;
    endtask

    task automatic frame_checks(input int exp_wr);
        check("frame_writes", 32'(n_wr - base_wr), 32'(exp_wr));
        check("frame_done_once", 32'(n_done - base_done), 32'd1);
        check("frame_wr_cnt", 32'(wr_cnt), 32'(exp_wr));
        check("frame_sb_empty", 32'(exp_q.size()), 32'd0);
        check("frame_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int first_rd, last_rd, cnt_rd, nrd;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        frame_len = '0;
        shift = '0;
        infifo_almst_empty = 1'b0;
        outfifo_almst_full = 1'b0;
        inbusy = 1'b0;
        repeat (3) tick;
        check("rst_rd_en", 32'(infifo_rd_en), 32'd0);
        check("rst_wr_en", 32'(outfifo_wr_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_din", 32'(outfifo_din), 32'd0);
        check("rst_wr_cnt", 32'(wr_cnt), 32'd0);
        rst_n = 1'b1;
        tick;

        // 8 steady full-scale words, half amplitude
        for (int i = 0; i < 8; i++) load(i, 18'h3FFFF, 14'h1FFF);
        start_frame(16'd8, 3'd1, 1'b0);
        first_rd = -1; last_rd = -1; cnt_rd = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (infifo_rd_en) begin
                if (first_rd < 0) first_rd = c;
                last_rd = c;
                cnt_rd++;
            end
            tick;
        end
        check("t1_rd_count", 32'(cnt_rd), 32'd8);
        check("t1_rd_span", 32'(last_rd - first_rd), 32'd7);
        wait_done(40);
        frame_checks(8);

        // output almost-full stall during RUN cycles 2-5, order preserved
        load(0, 18'h00010, 14'h0001);
        load(1, 18'h00123, 14'h0012);
        load(2, 18'h3FFF0, 14'h3FFF);
        load(3, 18'h2A5A5, 14'h2A5A);
        start_frame(16'd4, 3'd0, 1'b0);
        tick;
        outfifo_almst_full = 1'b1;
        repeat (4) tick;
        check("t2_rd_during_full", 32'(n_rd - base_rd), 32'd1);
        outfifo_almst_full = 1'b0;
        wait_done(40);
        frame_checks(4);

        // abort in the cycle of the 10th read of a 100-word frame
        for (int i = 0; i < 14; i++) load(i, 18'(i * 64 + 5), 14'(i));
        start_frame(16'd100, 3'd2, 1'b0);
        nrd = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (infifo_rd_en) nrd++;
            if (nrd == 10) begin
                abort = 1'b1;
                tick;
                abort = 1'b0;
                break;
            end
            tick;
        end
        wait_done(40);
        check("t3_reads", 32'(n_rd - base_rd), 32'd10);
        frame_checks(10);

        // zero-length frame: done three cycles after start
        start_frame(16'd0, 3'd0, 1'b0);
        check("t4_run_busy", 32'(busy), 32'd1);
        check("t4_done_c1", 32'(done), 32'd0);
        tick;
        check("t4_done_c2", 32'(done), 32'd0);
        tick;
        check("t4_done_c3", 32'(done), 32'd1);
        tick;
        check("t4_done_after", 32'(done), 32'd0);
        check("t4_no_reads", 32'(n_rd - base_rd), 32'd0);
        check("t4_no_writes", 32'(n_wr - base_wr), 32'd0);
        check("t4_wr_cnt", 32'(wr_cnt), 32'd0);
        check("t4_idle", 32'(busy), 32'd0);

        // reset with two reads in flight
        for (int i = 0; i < 8; i++) load(i, 18'h00100, 14'h0010);
        start_frame(16'd8, 3'd0, 1'b0);
        nrd = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (infifo_rd_en) nrd++;
            if (nrd == 2) break;
            tick;
        end
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t5_rst_rd_en", 32'(infifo_rd_en), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        repeat (3) tick;
        rst_n = 1'b1;
        repeat (4) tick;
        check("t5_no_writes", 32'(n_wr - base_wr), 32'd0);
        check("t5_din", 32'(outfifo_din), 32'd0);
        check("t5_wr_cnt", 32'(wr_cnt), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);

        // start while busy is ignored; input almost-empty stall
        load(0, 18'h00050, 14'h0005);
        load(1, 18'h000A0, 14'h000A);
        load(2, 18'h3FF00, 14'h3FF0);
        load(3, 18'h01230, 14'h0123);
        load(4, 18'h20000, 14'h2000);
        load(5, 18'h1FFFF, 14'h1FFF);
        start_frame(16'd6, 3'd0, 1'b0);
        tick;
        start = 1'b1;
        frame_len = 16'd2;
        infifo_almst_empty = 1'b1;
        tick;
        start = 1'b0;
        tick;
        infifo_almst_empty = 1'b0;
        wait_done(40);
        frame_checks(6);

        // start and abort together in IDLE, maximum shift, inbusy stall
        load(0, 18'h3FFFF, 14'h007F);
        load(1, 18'h12345, 14'h0024);
        load(2, 18'h00800, 14'h0001);
        start_frame(16'd3, 3'd7, 1'b1);
        inbusy = 1'b1;
        tick;
        inbusy = 1'b0;
        wait_done(40);
        frame_checks(3);

        // shift of three
        load(0, 18'h3FFFF, 14'h07FF);
        load(1, 18'h12345, 14'h0246);
        start_frame(16'd2, 3'd3, 1'b0);
        wait_done(40);
        frame_checks(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_scale_ctrl.md
FIFO_SCALE_CTRL -- requirements
Module: fifo_scale_ctrl

Interface
REQ-001 SHALL have parameter SAMPLE_RATE, default 4, meaning log2 of samples accumulated per input word.
REQ-002 SHALL have parameter DATA_WIDTH, default 14, meaning output sample width.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, meaning frame-length counter width.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle request to begin a frame.
REQ-007 SHALL have port abort  in  1  one-cycle request to stop issuing reads.
REQ-008 SHALL have port frame_len  in  LEN_WIDTH  number of words to move, sampled on accepted start.
REQ-009 SHALL have port shift  in  3  extra attenuation in bits, sampled on accepted start.
REQ-010 SHALL have port infifo_almst_empty  in  1  input FIFO almost-empty flag.
REQ-011 SHALL have port infifo_rd_en  out  1  input FIFO read strobe.
REQ-012 SHALL have port infifo_dout  in  DATA_WIDTH+SAMPLE_RATE  input FIFO data, valid one cycle after infifo_rd_en.
REQ-013 SHALL have port outfifo_almst_full  in  1  output FIFO almost-full flag.
REQ-014 SHALL have port inbusy  in  1  downstream/upstream busy stall.
REQ-015 SHALL have port outfifo_wr_en  out  1  output FIFO write strobe.
REQ-016 SHALL have port outfifo_din  out  DATA_WIDTH  scaled sample.
REQ-017 SHALL have port busy  out  1  high in any state except IDLE.
REQ-018 SHALL have port done  out  1  one-cycle pulse at frame end.
REQ-019 SHALL have port wr_cnt  out  LEN_WIDTH  words written in current/last frame.

Function
REQ-020 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-021 IDLE->RUN on start; frame_len, shift latched, wr_cnt and read count cleared; start ignored outside IDLE.
REQ-022 In RUN, infifo_rd_en SHALL be high exactly when !infifo_almst_empty && !outfifo_almst_full && !inbusy && read count < latched frame_len.
REQ-023 RUN->DRAIN when read count reaches frame_len or abort is high; abort in IDLE/DRAIN/DONE ignored.
REQ-024 Pipeline: read at cycle t; infifo_dout captured at t+1; outfifo_wr_en and outfifo_din registered high at t+2 (fixed 2-cycle latency, no stall once read issued).
REQ-025 outfifo_din SHALL equal (infifo_dout >> (SAMPLE_RATE + shift))[DATA_WIDTH-1:0], unsigned, truncating; shift=1 gives half amplitude.
REQ-026 wr_cnt SHALL increment on every outfifo_wr_en.
REQ-027 DRAIN->DONE when no read is in flight (both pipeline valid bits low).
REQ-028 DONE SHALL assert done for one cycle, then return to IDLE; wr_cnt holds until next accepted start.
REQ-029 frame_len=0: RUN issues no reads, DRAIN then DONE, done pulses 3 cycles after start.
REQ-030 start and abort in the same IDLE cycle: start accepted, abort ignored.
REQ-031 Counters SHALL not wrap: frame_len max 2^LEN_WIDTH-1.

Reset
REQ-032 On rst_n low: state IDLE; infifo_rd_en, outfifo_wr_en, busy, done 0; outfifo_din 0; wr_cnt 0; pipeline valids cleared.
REQ-033 Reset mid-frame SHALL discard in-flight data with no further writes.

Structure
REQ-034 State encoding and latency constant (2) SHALL live in shared package adda_pkg.
REQ-035 Scaling shift/truncate SHALL be a sub-module amp_scale (combinational, parameterised SAMPLE_RATE, DATA_WIDTH).

Verification
REQ-036 frame_len=8, shift=1, input words 0x3FFFF steady, no stalls -> 8 writes of 0x1FFF, reads on 8 consecutive cycles, done once.
REQ-037 frame_len=4, outfifo_almst_full high cycles 2-5 of RUN -> no reads while high, 4 writes total, data order preserved.
REQ-038 frame_len=100, abort after 10th read -> exactly 10 writes, wr_cnt=10, done pulses.
REQ-039 frame_len=0 -> no rd_en/wr_en, done 3 cycles after start.
REQ-040 rst_n low with 2 reads in flight -> no outfifo_wr_en after reset, all outputs 0, state IDLE.
REQ-041 start pulsed while busy -> ignored, latched frame_len unchanged.
